nv_nvdla_cvif_noc_rd_rsp: RTL

AXI read responder for the CVIF read path. It accepts AR requests on the `cvif2noc_axi_ar_*` channel, queues them with an accept timestamp, and returns the address-derived data pattern on the R channel after a programmable minimum latency. It closes the CVIF read ingress loop in block-level and subsystem benches, and in FPGA bring-up builds without a real NOC.

---
 rtl/nv_nvdla_cvif_noc_rd_rsp_pkg.sv | 39 +++
 rtl/nv_nvdla_cvif_noc_rd_rsp_if.sv | 30 +++
 rtl/nv_nvdla_cvif_noc_rd_rsp_fifo.sv | 54 +++++
 rtl/nv_nvdla_cvif_noc_rd_rsp.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_cvif_noc_rd_rsp_pkg.sv
// Shared types and constants for the CVIF NOC read responder.
// Optional feature macro used by the top level: NVDLA_CVIF_RSP_BACKPRESSURE_EN.
package nv_nvdla_cvif_rsp_pkg;

  localparam int DATA_W     = 512;
  localparam int BEAT_BYTES = 64;
  localparam int STAMP_W    = 16;
  localparam int LANES      = DATA_W / 64;

  // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [7:0]         id;
    logic [3:0]         len;
    logic [57:0]        addr;
    logic [STAMP_W-1:0] stamp;
  } rsp_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rsp_state_e;

  // Beat payload: each 64-bit lane carries its own byte address within the beat
  function automatic logic [DATA_W-1:0] beat_data(input logic [57:0] line,
                                                  input logic [3:0]  beat);
    logic [63:0]       base;
    logic [DATA_W-1:0] d;
    base = {line, 6'b0} + {54'b0, beat, 6'b0};
    d    = '0;
    for (int k = 0; k < LANES; k++) begin
      d[64*k +: 64] = base + 64'(8 * k);
    end
    return d;
  endfunction

endpackage

// File: rtl/nv_nvdla_cvif_noc_rd_rsp_if.sv
// AR/R channel bundle between the CVIF read client and the NOC responder.
interface nv_nvdla_cvif_noc_rd_rsp_if;
  import nv_nvdla_cvif_rsp_pkg::*;

  logic              cvif2noc_axi_ar_arvalid;
  logic              cvif2noc_axi_ar_arready;
  logic [7:0]        cvif2noc_axi_ar_arid;
  logic [3:0]        cvif2noc_axi_ar_arlen;
  logic [63:0]       cvif2noc_axi_ar_araddr;
  logic              noc2cvif_axi_r_rvalid;
  logic              noc2cvif_axi_r_rready;
  logic [7:0]        noc2cvif_axi_r_rid;
  logic              noc2cvif_axi_r_rlast;
  logic [DATA_W-1:0] noc2cvif_axi_r_rdata;

  modport master (
    output cvif2noc_axi_ar_arvalid, cvif2noc_axi_ar_arid, cvif2noc_axi_ar_arlen,
           cvif2noc_axi_ar_araddr, noc2cvif_axi_r_rready,
    input  cvif2noc_axi_ar_arready, noc2cvif_axi_r_rvalid, noc2cvif_axi_r_rid,
           noc2cvif_axi_r_rlast, noc2cvif_axi_r_rdata
  );

  modport slave (
    input  cvif2noc_axi_ar_arvalid, cvif2noc_axi_ar_arid, cvif2noc_axi_ar_arlen,
           cvif2noc_axi_ar_araddr, noc2cvif_axi_r_rready,
    output cvif2noc_axi_ar_arready, noc2cvif_axi_r_rvalid, noc2cvif_axi_r_rid,
           noc2cvif_axi_r_rlast, noc2cvif_axi_r_rdata
  );

endinterface

// File: rtl/nv_nvdla_cvif_noc_rd_rsp_fifo.sv
// Request queue: synchronous FIFO of rsp_entry_t with an occupancy count.
// Head is read combinationally; callers never push when full or pop when empty.
module nv_nvdla_cvif_rsp_fifo
  import nv_nvdla_cvif_rsp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  rsp_entry_t             i_data,
  input  logic                   i_pop,
  output rsp_entry_t             o_head,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  rsp_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  // Storage write; contents need no reset since the count gates every read
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_FULL);
  assign o_count = r_count;

endmodule

// File: rtl/nv_nvdla_cvif_noc_rd_rsp.sv
// CVIF read responder: queues AR requests with an accept timestamp and returns
// address-pattern R bursts in order after a minimum latency of RSP_DELAY.
// Optional macro NVDLA_CVIF_RSP_BACKPRESSURE_EN adds LFSR-driven AR/R stalls.
//
//   state    | meaning
//   ST_IDLE  | no burst in progress; next beat comes from an eligible head entry
//   ST_BURST | head entry partially returned; r_beat is the next beat index
module nv_nvdla_cvif_noc_rd_rsp
  import nv_nvdla_cvif_rsp_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int RSP_DELAY = 8
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  nv_nvdla_cvif_noc_rd_rsp_if.slave axi,
  output logic [$clog2(DEPTH):0] rsp_os_cnt
);

  localparam logic [STAMP_W-1:0] DELAY = STAMP_W'(RSP_DELAY);

  logic [STAMP_W-1:0] r_stamp;
  rsp_state_e         r_state;
  rsp_state_e         w_state_nxt;
  logic [3:0]         r_beat;
  logic [3:0]         w_beat_nxt;
  logic               r_rvalid;
  logic               r_rlast;
  logic [7:0]         r_rid;
  logic [DATA_W-1:0]  r_rdata;

  rsp_entry_t w_push_entry;
  rsp_entry_t w_fifo_head;
  rsp_entry_t w_head;
  logic       w_fifo_empty;
  logic       w_fifo_full;
  logic       w_arready;
  logic       w_push;
  logic       w_head_vld;
  logic       w_elig;
  logic       w_avail;
  logic       w_load;
  logic       w_take;
  logic       w_last;
  logic       w_pop;
  logic [3:0] w_b;
  logic       w_lfsr_ar_ok;
  logic       w_lfsr_r_ok;
  logic       w_unused_addr;

`ifdef NVDLA_CVIF_RSP_BACKPRESSURE_EN
  logic [15:0] r_lfsr;

  // Pseudo-random stall source, advances every cycle
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) r_lfsr <= LFSR_SEED;
    else                r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign w_lfsr_ar_ok = (r_lfsr[1:0] != 2'b00);
  assign w_lfsr_r_ok  = (r_lfsr[3:2] != 2'b00);
`else
  assign w_lfsr_ar_ok = 1'b1;
  assign w_lfsr_r_ok  = 1'b1;
`endif

  assign w_unused_addr = ^axi.cvif2noc_axi_ar_araddr[5:0];

  assign w_arready    = !w_fifo_full && !nvdla_core_rst && w_lfsr_ar_ok;
  assign w_push       = axi.cvif2noc_axi_ar_arvalid && w_arready;
  assign w_push_entry = '{id:    axi.cvif2noc_axi_ar_arid,
                          len:   axi.cvif2noc_axi_ar_arlen,
                          addr:  axi.cvif2noc_axi_ar_araddr[63:6],
                          stamp: r_stamp};

  // An empty queue falls through to the incoming request so RSP_DELAY=0
  // can answer in the very next cycle.
  assign w_head     = w_fifo_empty ? w_push_entry : w_fifo_head;
  assign w_head_vld = !w_fifo_empty || w_push;
  assign w_elig     = ((r_stamp - w_head.stamp) >= DELAY);

  nv_nvdla_cvif_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (nvdla_core_clk),
    .rst     (nvdla_core_rst),
    .i_push  (w_push && !(w_fifo_empty && w_pop)),
    .i_data  (w_push_entry),
    .i_pop   (w_pop && !w_fifo_empty),
    .o_head  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (rsp_os_cnt)
  );

  // Free-running accept timestamp
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) r_stamp <= '0;
    else                r_stamp <= r_stamp + 1'b1;
  end

  // Burst sequencing: pick the next beat and retire the entry on its last beat
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_pop       = 1'b0;
    w_b         = (r_state == ST_BURST) ? r_beat : 4'd0;
    w_avail     = (r_state == ST_BURST) || (w_head_vld && w_elig);
    w_load      = !r_rvalid || axi.noc2cvif_axi_r_rready;
    w_take      = w_load && w_avail && w_lfsr_r_ok;
    w_last      = (w_b == w_head.len);
    if (w_take) begin
      if (w_last) begin
        w_pop       = 1'b1;
        w_state_nxt = ST_IDLE;
        w_beat_nxt  = 4'd0;
      end else begin
        w_state_nxt = ST_BURST;
        w_beat_nxt  = w_b + 4'd1;
      end
    end
  end

  // Burst state and beat index
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state <= ST_IDLE;
      r_beat  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // R output register; drops valid once the held beat is taken and nothing follows
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
    end else if (w_load) begin
      r_rvalid <= w_take;
      if (w_take) begin
        r_rid   <= w_head.id;
        r_rlast <= w_last;
        r_rdata <= beat_data(w_head.addr, w_b);
      end else begin
        r_rlast <= 1'b0;
      end
    end
  end

  assign axi.cvif2noc_axi_ar_arready = w_arready;
  assign axi.noc2cvif_axi_r_rvalid   = r_rvalid;
  assign axi.noc2cvif_axi_r_rid      = r_rid;
  assign axi.noc2cvif_axi_r_rlast    = r_rlast;
  assign axi.noc2cvif_axi_r_rdata    = r_rdata;

endmodule
